// File: rtl/bayer_demosaic.sv
// bayer_demosaic: one-line-buffer 2x2 quad demosaic of a 12-bit Bayer stream, 2-cycle latency.
// Optional raw passthrough on the new iBypass input when BAYER_BYPASS_EN is defined.
module bayer_demosaic #(
  parameter int         LINE_WIDTH  = 1280,
  parameter int         ADDR_W      = 11,
  parameter logic [1:0] BAYER_PHASE = 2'b00
) (
  input  logic        CCD_PIXCLK,
  input  logic        iRst_n,
`ifdef BAYER_BYPASS_EN
  input  logic        iBypass,
`endif
  input  logic [11:0] iData,
  input  logic        iDval,
  input  logic [15:0] iX_Cont,
  input  logic [15:0] iY_Cont,
  input  logic        iFval,
  output logic [11:0] oRed,
  output logic [11:0] oGreen,
  output logic [11:0] oBlue,
  output logic [15:0] oX_Cont,
  output logic [15:0] oY_Cont,
  output logic        oDval
);
  localparam logic [15:0] LW = 16'(LINE_WIDTH);
  typedef enum logic {WAIT_FRAME, ACTIVE} state_t;
  state_t state_q, state_d;
  logic        fval_q, acc, in_rng, byp;
  logic [11:0] ram [LINE_WIDTH];
  logic [11:0] rd_q, c_q, l_q, tl_q;
  logic [15:0] x1_q, y1_q;
  logic        v1_q, t_ok_q;
  logic [11:0] t_w, l_w, tl_w, r_d, g_d, b_d;
  logic [12:0] sum_ctl, sum_lt;
  logic [1:0]  p;
  logic [11:0] red_q, green_q, blue_q;
  logic [15:0] x_q, y_q;
  logic        dval_q;
`ifdef BAYER_BYPASS_EN
  assign byp = iBypass;
`else
  assign byp = 1'b0;
`endif
  assign acc    = (state_q == ACTIVE) && iDval;
  assign in_rng = iX_Cont < LW;
  always_comb begin
    state_d = (state_q == WAIT_FRAME) ? ((iFval && !fval_q) ? ACTIVE : WAIT_FRAME)
                                      : ((!iFval && fval_q) ? WAIT_FRAME : ACTIVE);
  end
  always_ff @(posedge CCD_PIXCLK) begin
    if (acc && in_rng) begin
      rd_q <= ram[iX_Cont[ADDR_W-1:0]];
      ram[iX_Cont[ADDR_W-1:0]] <= iData;
    end
  end
  // fval_q resets high so a reset released mid-frame waits for the next full frame
  always_ff @(posedge CCD_PIXCLK or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= WAIT_FRAME;
      fval_q  <= 1'b1;
      v1_q    <= 1'b0;
      c_q     <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      t_ok_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fval_q  <= iFval;
      v1_q    <= acc;
      if (acc) begin
        c_q    <= iData;
        x1_q   <= iX_Cont;
        y1_q   <= iY_Cont;
        t_ok_q <= in_rng && (iY_Cont != 16'd0);
      end
    end
  end
  always_comb begin
    t_w     = t_ok_q ? rd_q : '0;
    l_w     = (x1_q == 16'd0) ? '0 : l_q;
    tl_w    = ((x1_q == 16'd0) || !t_ok_q) ? '0 : tl_q;
    sum_ctl = {1'b0, c_q} + {1'b0, tl_w};
    sum_lt  = {1'b0, l_w} + {1'b0, t_w};
    p       = {y1_q[0], x1_q[0]} ^ BAYER_PHASE;
    r_d     = (p == 2'b00) ? l_w : (p == 2'b01) ? c_q : (p == 2'b10) ? tl_w : t_w;
    b_d     = (p == 2'b00) ? t_w : (p == 2'b01) ? tl_w : (p == 2'b10) ? c_q : l_w;
    g_d     = (p[0] == p[1]) ? sum_ctl[12:1] : sum_lt[12:1];
  end
  always_ff @(posedge CCD_PIXCLK or negedge iRst_n) begin
    if (!iRst_n) begin
      dval_q  <= 1'b0;
      l_q     <= '0;
      tl_q    <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      dval_q <= v1_q;
      if (v1_q) begin
        l_q     <= c_q;
        tl_q    <= t_w;
        red_q   <= byp ? c_q : r_d;
        green_q <= byp ? c_q : g_d;
        blue_q  <= byp ? c_q : b_d;
        x_q     <= x1_q;
        y_q     <= y1_q;
      end
    end
  end
  assign oRed    = red_q;
  assign oGreen  = green_q;
  assign oBlue   = blue_q;
  assign oX_Cont = x_q;
  assign oY_Cont = y_q;
  assign oDval   = dval_q;
endmodule

// File: tb/tb_bayer_demosaic.sv
// tb_bayer_demosaic: table vectors, hand sequences and a random frame model for bayer_demosaic.
module tb_bayer_demosaic;
  localparam int LW = 8;
  localparam int AW = 3;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [11:0] data = '0;
  logic        dval = 1'b0, fval = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic [11:0] o_r, o_g, o_b;
  logic [15:0] o_x, o_y;
  logic        o_dv;
  int tests = 0, fails = 0;
`ifdef BAYER_BYPASS_EN
  logic byp = 1'b0;
`endif

  always #5 clk = ~clk;

  bayer_demosaic #(.LINE_WIDTH(LW), .ADDR_W(AW), .BAYER_PHASE(2'b00)) dut (
    .CCD_PIXCLK(clk), .iRst_n(rst_n),
`ifdef BAYER_BYPASS_EN
    .iBypass(byp),
`endif
    .iData(data), .iDval(dval), .iX_Cont(x), .iY_Cont(y), .iFval(fval),
    .oRed(o_r), .oGreen(o_g), .oBlue(o_b), .oX_Cont(o_x), .oY_Cont(o_y), .oDval(o_dv)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: previous-row memory, last accepted pixel and its top neighbour.
  typedef struct packed {logic v; logic [11:0] r, g, b; logic [15:0] x, y;} out_t;
  out_t hold, q[$];
  logic [11:0] lb [LW];
  logic [11:0] lc, ltl;
  bit active, fprev;

  function automatic out_t pix(input logic [15:0] px, input logic [15:0] py, input logic [11:0] d);
    out_t o;
    int c, t, l, tl, gs;
    logic [1:0] p;
    bit inr;
    inr = px < LW;
    c   = int'(d);
    t   = (py == 0 || !inr) ? 0 : int'(lb[px[AW-1:0]]);
    l   = (px == 0) ? 0 : int'(lc);
    tl  = (px == 0 || py == 0 || !inr) ? 0 : int'(ltl);
    if (inr) lb[px[AW-1:0]] = d;
    lc  = d;
    ltl = 12'(t);
    p   = {py[0], px[0]};
    gs  = (p == 2'b00 || p == 2'b11) ? (c + tl) / 2 : (l + t) / 2;
    case (p)
      2'b00: begin o.r = 12'(l);  o.b = 12'(t);  end
      2'b01: begin o.r = 12'(c);  o.b = 12'(tl); end
      2'b10: begin o.r = 12'(tl); o.b = 12'(c);  end
      default: begin o.r = 12'(t); o.b = 12'(l); end
    endcase
    o.g = 12'(gs);
    o.v = 1'b1;
    o.x = px;
    o.y = py;
    return o;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      active = 0;
      fprev  = 1;
      hold   = '0;
    end else begin
      if (active && dval) hold = pix(x, y, data);
      else hold.v = 1'b0;
      if (!active && fval && !fprev) active = 1;
      else if (active && !fval && fprev) active = 0;
      fprev = fval;
    end
    q.push_back(hold);
  end

  always @(negedge clk) begin
    if (q.size() >= 2) begin
      chk("model", {11'b0, o_dv, o_r, o_g, o_b, o_x, o_y}, {11'b0, q[q.size()-2]});
      while (q.size() > 2) void'(q.pop_front());
    end
  end

  typedef struct {int x, y, d, r, g, b;} vec_t;
  vec_t tbl[16];

  task automatic send(input int px, input int py, input int d);
    @(negedge clk);
    x = 16'(px); y = 16'(py); data = 12'(d); dval = 1'b1;
    @(negedge clk);
    dval = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame_start();
    @(negedge clk); fval = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk); dval = 1'b0; fval = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bit pat[6];
    int w, h;
    tbl[0]  = '{0, 0, 100,  0,   50,   0};
    tbl[1]  = '{1, 0, 200,  200, 50,   0};
    tbl[2]  = '{2, 0, 100,  200, 50,   0};
    tbl[3]  = '{3, 0, 200,  200, 50,   0};
    tbl[4]  = '{0, 1, 300,  0,   50,   300};
    tbl[5]  = '{1, 1, 400,  200, 250,  300};
    tbl[6]  = '{2, 1, 300,  200, 250,  300};
    tbl[7]  = '{3, 1, 400,  200, 250,  300};
    tbl[8]  = '{0, 2, 4095, 0,   2047, 300};
    tbl[9]  = '{1, 2, 10,   10,  2247, 300};
    tbl[10] = '{0, 3, 20,   0,   2047, 20};
    tbl[11] = '{1, 3, 4095, 10,  4095, 20};
    tbl[12] = '{0, 4, 4094, 0,   2047, 20};
    tbl[13] = '{1, 4, 30,   30,  4094, 20};
    tbl[14] = '{0, 5, 40,   0,   2047, 40};
    tbl[15] = '{1, 5, 4095, 30,  4094, 40};
    pat = '{1, 0, 0, 1, 0, 0};

    fval = 1'b1;
    repeat (6) begin @(negedge clk); dval = ~dval; x = x + 16'd1; end
    chk("reset_outputs", {o_dv, o_r, o_g, o_b, o_x, o_y}, '0);
    @(negedge clk); rst_n = 1'b1;
    repeat (8) begin @(negedge clk); dval = ~dval; chk("midframe_no_dval", o_dv, 1'b0); end
    frame_end();

    frame_start();
    foreach (tbl[i]) begin
      send(tbl[i].x, tbl[i].y, tbl[i].d);
      chk("tbl_dval", o_dv, 1'b1);
      chk("tbl_rgb", {o_r, o_g, o_b}, {12'(tbl[i].r), 12'(tbl[i].g), 12'(tbl[i].b)});
      chk("tbl_xy", {o_x, o_y}, {16'(tbl[i].x), 16'(tbl[i].y)});
    end
    frame_end();

    frame_start();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) chk("bubble_dval", o_dv, pat[i-2]);
      if (i == 5) chk("bubble_x_l_hold", {o_x, o_g}, {16'd3, 12'd500});
      dval = pat[i]; x = 16'(i); y = 16'd0; data = (i == 0) ? 12'd1000 : 12'd3000;
    end
    frame_end();

    frame_start();
    send(2, 0, 0);
    send(3, 0, 600);
    send(2, 1, 0);
    send(LW + 3, 1, 999);
    chk("oob_green", o_g, 12'd499);
    chk("oob_red_blue", {o_r, o_b}, 24'd0);
    send(2, 2, 0);
    send(3, 2, 0);
    chk("ram_kept_green", o_g, 12'd300);
    frame_end();

    for (int f = 0; f < 5; f++) begin
      w = $urandom_range(2, LW + 4);
      h = $urandom_range(2, 5);
      frame_start();
      for (int yy = 0; yy < h; yy++)
        for (int xx = 0; xx < w; xx++) begin
          if ($urandom_range(0, 2) == 0) begin @(negedge clk); dval = 1'b0; end
          @(negedge clk);
          dval = 1'b1; x = 16'(xx); y = 16'(yy); data = 12'($urandom_range(0, 4095));
        end
      frame_end();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
